// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the fetch stage: one registered fetch per cycle,
// stall/flush from the hazard unit, an out-of-range fault flag and a run-time write port.
module instr_mem_sync #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,
    parameter bit                BYTE_ADDR = 1'b0,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fault,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // Port 0 is the fetch address, port 1 the write address; both share the addressing mode.
    logic [ADDR_W-1:0] addr_in  [2];
    logic [ADDR_W-1:0] word_idx [2];
    logic              in_range [2];
    logic [IDX_W-1:0]  mem_idx  [2];

    assign addr_in[0] = pc;
    assign addr_in[1] = wr_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_idx
            if (BYTE_ADDR) begin : g_byte
                assign word_idx[gi] = addr_in[gi] >> 2;
            end else begin : g_word
                assign word_idx[gi] = addr_in[gi];
            end
            assign in_range[gi] = ({1'b0, word_idx[gi]} < DEPTH_EXT);
            assign mem_idx[gi]  = word_idx[gi][IDX_W-1:0];
        end
    endgenerate

    logic wr_accept;
    assign wr_accept = !rst && wr_en && in_range[1];

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[mem_idx[1]] <= wr_data;
        end
    end

    logic [DATA_W-1:0] instr_reg,  instr_next;
    logic              valid_reg,  valid_next;
    logic [ADDR_W-1:0] pc_reg,     pc_next;
    logic              fault_reg,  fault_next;
    logic [DATA_W-1:0] rd_data;

    // Write-first: a same-edge write to the fetched word is forwarded to the fetch.
    assign rd_data = (wr_accept && (mem_idx[1] == mem_idx[0])) ? wr_data : mem[mem_idx[0]];

    always_comb begin
        instr_next = instr_reg;
        valid_next = valid_reg;
        pc_next    = pc_reg;
        fault_next = fault_reg;
        if (flush) begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
            fault_next = 1'b0;
        end else if (stall) begin
            instr_next = instr_reg;
        end else if (req) begin
            valid_next = 1'b1;
            pc_next    = pc;
            if (in_range[0]) begin
                instr_next = rd_data;
                fault_next = 1'b0;
            end else begin
                instr_next = NOP_INSTR;
                fault_next = 1'b1;
            end
        end else begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
            fault_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            fault_reg <= 1'b0;
        end else begin
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            pc_reg    <= pc_next;
            fault_reg <= fault_next;
        end
    end

    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign instr_pc    = pc_reg;
    assign fault       = fault_reg;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: a word-addressed and a byte-addressed instance driven by directed
// and random stimulus, each compared every cycle against a behavioural model.
module tb_instr_mem_sync;

    logic        clk;
    logic        rst;
    logic        req      [2];
    logic [31:0] pc       [2];
    logic        stall    [2];
    logic        flush    [2];
    logic        wr_en    [2];
    logic [31:0] wr_addr  [2];
    logic [31:0] wr_data  [2];
    logic [31:0] instr    [2];
    logic        valid    [2];
    logic [31:0] ipc      [2];
    logic        fault    [2];

    // Reference state
    logic [31:0] mem_m    [2][256];
    logic [31:0] e_instr  [2];
    logic        e_valid  [2];
    logic [31:0] e_pc     [2];
    logic        e_fault  [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    instr_mem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .BYTE_ADDR(1'b0),
                     .NOP_INSTR(32'h0000_0000)) u_word (
        .clk(clk), .rst(rst), .req(req[0]), .pc(pc[0]), .stall(stall[0]), .flush(flush[0]),
        .instr(instr[0]), .instr_valid(valid[0]), .instr_pc(ipc[0]), .fault(fault[0]),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]));

    instr_mem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(200), .BYTE_ADDR(1'b1),
                     .NOP_INSTR(32'h0000_0013)) u_byte (
        .clk(clk), .rst(rst), .req(req[1]), .pc(pc[1]), .stall(stall[1]), .flush(flush[1]),
        .instr(instr[1]), .instr_valid(valid[1]), .instr_pc(ipc[1]), .fault(fault[1]),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint depth_of(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    function automatic bit byte_of(input int k);
        return k == 1;
    endfunction

    function automatic logic [31:0] nop_of(input int k);
        return (k == 0) ? 32'h0000_0000 : 32'h0000_0013;
    endfunction

    function automatic longint word_of(input int k, input logic [31:0] a);
        longint w;
        w = longint'(a);
        return byte_of(k) ? (w / 4) : w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock edge of the intended behaviour, evaluated on the inputs present at that edge.
    task automatic model_edge(input int k);
        longint idx, widx;
        if (rst) begin
            e_instr[k] = nop_of(k);
            e_valid[k] = 1'b0;
            e_pc[k]    = 32'd0;
            e_fault[k] = 1'b0;
        end else begin
            widx = word_of(k, wr_addr[k]);
            if (wr_en[k] && widx < depth_of(k)) mem_m[k][int'(widx)] = wr_data[k];
            if (flush[k]) begin
                e_instr[k] = nop_of(k);
                e_valid[k] = 1'b0;
                e_fault[k] = 1'b0;
            end else if (!stall[k]) begin
                if (req[k]) begin
                    idx        = word_of(k, pc[k]);
                    e_valid[k] = 1'b1;
                    e_pc[k]    = pc[k];
                    if (idx < depth_of(k)) begin
                        e_instr[k] = mem_m[k][int'(idx)];
                        e_fault[k] = 1'b0;
                    end else begin
                        e_instr[k] = nop_of(k);
                        e_fault[k] = 1'b1;
                    end
                end else begin
                    e_instr[k] = nop_of(k);
                    e_valid[k] = 1'b0;
                    e_fault[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d instr", k), instr[k], e_instr[k]);
            check($sformatf("d%0d valid", k), 32'(valid[k]), 32'(e_valid[k]));
            check($sformatf("d%0d instr_pc", k), ipc[k], e_pc[k]);
            check($sformatf("d%0d fault", k), 32'(fault[k]), 32'(e_fault[k]));
        end
        $display("cyc %0d rst=%0b | w: v=%0b pc=%h i=%h f=%0b | b: v=%0b pc=%h i=%h f=%0b",
                 cyc, rst, valid[0], ipc[0], instr[0], fault[0],
                 valid[1], ipc[1], instr[1], fault[1]);
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; pc[k] = 32'd0; stall[k] = 1'b0; flush[k] = 1'b0;
            wr_en[k] = 1'b0; wr_addr[k] = 32'd0; wr_data[k] = 32'd0;
        end
    endtask

    function automatic logic [31:0] rand_addr(input int k);
        int w;
        w = int'($urandom_range(0, 32'(depth_of(k)) + 8));
        if ($urandom_range(0, 15) == 0) return $urandom;
        return byte_of(k) ? 32'(w * 4 + int'($urandom_range(0, 3))) : 32'(w);
    endfunction

    logic [31:0] p2_vals [4];

    initial begin
        p2_vals[0] = 32'h11; p2_vals[1] = 32'h22; p2_vals[2] = 32'h33; p2_vals[3] = 32'h44;
        rst = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;

        // Reset with fetch requests present.
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin req[k] = 1'b1; pc[k] = 32'd5; end
        repeat (2) begin
            step();
            check("rst instr", instr[0], 32'h0);
            check("rst valid", 32'(valid[0]), 32'd0);
        end
        rst = 1'b0;
        idle_all();

        // Program every word of both instances with random contents.
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 2; k++) begin
                wr_en[k]   = 1'b1;
                wr_addr[k] = byte_of(k) ? 32'(i * 4) : 32'(i);
                wr_data[k] = $urandom;
            end
            step();
        end
        idle_all();

        // Four writes, then four back-to-back fetches.
        for (int j = 0; j < 4; j++) begin
            wr_en[0] = 1'b1; wr_addr[0] = 32'(j); wr_data[0] = p2_vals[j];
            step();
        end
        idle_all();
        for (int j = 0; j < 4; j++) begin
            req[0] = 1'b1; pc[0] = 32'(j);
            step();
            check("b2b instr", instr[0], p2_vals[j]);
            check("b2b pc", ipc[0], 32'(j));
            check("b2b valid", 32'(valid[0]), 32'd1);
        end
        idle_all();
        step();

        // Stall holds a fetched word even while it is overwritten.
        req[0] = 1'b1; pc[0] = 32'd2;
        step();
        for (int j = 0; j < 3; j++) begin
            stall[0] = 1'b1; pc[0] = 32'(j + 7);
            wr_en[0] = 1'b1; wr_addr[0] = 32'd2; wr_data[0] = 32'hAA;
            step();
            check("stall instr", instr[0], 32'h33);
            check("stall pc", ipc[0], 32'd2);
        end
        idle_all();
        req[0] = 1'b1; pc[0] = 32'd2;
        step();
        check("post-stall instr", instr[0], 32'hAA);

        // Flush wins over stall and req.
        flush[0] = 1'b1; stall[0] = 1'b1; req[0] = 1'b1; pc[0] = 32'd1;
        step();
        check("flush valid", 32'(valid[0]), 32'd0);
        check("flush instr", instr[0], 32'h0);
        idle_all();

        // Out-of-range fetch and write on the word instance, then the range edge.
        req[0] = 1'b1; pc[0] = 32'd300;
        step();
        check("oor fault", 32'(fault[0]), 32'd1);
        check("oor valid", 32'(valid[0]), 32'd1);
        check("oor pc", ipc[0], 32'd300);
        idle_all();
        wr_en[0] = 1'b1; wr_addr[0] = 32'd300; wr_data[0] = 32'hDEAD;
        step();
        idle_all();
        req[0] = 1'b1; pc[0] = 32'd255; step();
        check("last word fault", 32'(fault[0]), 32'd0);
        pc[0] = 32'd256; step();
        check("depth fault", 32'(fault[0]), 32'd1);
        pc[0] = 32'd44; step();
        idle_all();

        // Byte instance: same-edge write/fetch collision with ignored low pc bits.
        wr_en[1] = 1'b1; wr_addr[1] = 32'd8; wr_data[1] = 32'hBEEF;
        req[1] = 1'b1; pc[1] = 32'd11;
        step();
        check("collide instr", instr[1], 32'hBEEF);
        check("collide pc", ipc[1], 32'd11);
        idle_all();
        req[1] = 1'b1; pc[1] = 32'd799; step();
        check("byte last fault", 32'(fault[1]), 32'd0);
        pc[1] = 32'd800; step();
        check("byte depth fault", 32'(fault[1]), 32'd1);
        check("byte depth nop", instr[1], 32'h13);
        idle_all();

        // Random traffic on both instances.
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < 2; k++) begin
                req[k]     = ($urandom_range(0, 3) != 0);
                stall[k]   = ($urandom_range(0, 4) == 0);
                flush[k]   = ($urandom_range(0, 9) == 0);
                pc[k]      = rand_addr(k);
                wr_en[k]   = ($urandom_range(0, 9) < 3);
                wr_addr[k] = ($urandom_range(0, 3) == 0) ? pc[k] : rand_addr(k);
                wr_data[k] = $urandom;
            end
            step();
        end
        rst = 1'b0;
        idle_all();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
